// File: rtl/spram_pkg.sv
// rtl/spram_pkg.sv - shared defaults, depth helper and word type for single_port_ram
package spram_pkg;

    localparam int SPRAM_DATA_WIDTH = 8;
    localparam int SPRAM_ADDR_WIDTH = 6;

    // Word type at the default width; the RAM redeclares its own word type from its parameters.
    typedef logic [SPRAM_DATA_WIDTH-1:0] spram_word_t;

    function automatic int spram_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/spram_out_reg.sv
// rtl/spram_out_reg.sv - optional registered read stage, cleared by synchronous active-high reset
module spram_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = d_i;
        if (rst_i) begin
            data_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    assign q_o = data_q;

endmodule

// File: rtl/single_port_ram.sv
// rtl/single_port_ram.sv - single-port RAM, sync write, comb read; SPRAM_OUT_REG_EN adds an output register
module single_port_ram
    import spram_pkg::*;
#(
    parameter int IN_DATA_WIDTH = SPRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH    = SPRAM_ADDR_WIDTH
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [IN_DATA_WIDTH-1:0] Data,
    input  logic [ADDR_WIDTH-1:0]    Address,
    input  logic                     WE,
    output logic [IN_DATA_WIDTH-1:0] Output
);

    localparam int DEPTH = spram_depth(ADDR_WIDTH);

    typedef logic [IN_DATA_WIDTH-1:0] word_t;

    word_t mem_q [DEPTH];
    word_t rd_data;

    // Reset clears the whole array in one edge and wins over a coincident write.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (WE) begin
            mem_q[Address] <= Data;
        end
    end

    assign rd_data = mem_q[Address];

`ifdef SPRAM_OUT_REG_EN
    // rd_data still holds the pre-write word at the edge, giving read-first behaviour.
    spram_out_reg #(
        .WIDTH(IN_DATA_WIDTH)
    ) u_out_reg (
        .clk_i(CLK),
        .rst_i(RST),
        .d_i  (rd_data),
        .q_o  (Output)
    );
`else
    assign Output = rd_data;
`endif

endmodule

// File: tb/tb_single_port_ram.sv
// tb/tb_single_port_ram.sv - directed and random checks of single_port_ram against an array model
module tb_single_port_ram;

    localparam int DW = 8;
    localparam int AW = 6;
    localparam int DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] Data;
    logic [AW-1:0] Address;
    logic          WE;
    logic [DW-1:0] Output;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_out = '0;

    single_port_ram #(
        .IN_DATA_WIDTH(DW),
        .ADDR_WIDTH   (AW)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .Data   (Data),
        .Address(Address),
        .WE     (WE),
        .Output (Output)
    );

    always #5 CLK = ~CLK;

    // Reference: a plain array updated at each edge; ref_out is the read-first registered view.
    always @(posedge CLK) begin
        ref_out = RST ? '0 : ref_mem[Address];
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end else if (WE) begin
            ref_mem[Address] = Data;
        end
    end

    function automatic logic [DW-1:0] model_output();
`ifdef SPRAM_OUT_REG_EN
        return ref_out;
`else
        return ref_mem[Address];
`endif
    endfunction

    always @(negedge CLK) begin
        if (chk_en) begin
            n_checks++;
            if (Output !== model_output()) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t addr=%0d got=%h exp=%h", $time, Address, Output, model_output());
            end
        end
    end

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        WE = 1'b1; Address = a; Data = d;
        @(posedge CLK); #1;
        WE = 1'b0;
    endtask

    task automatic read_expect(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        Address = a; WE = 1'b0;
`ifdef SPRAM_OUT_REG_EN
        @(posedge CLK); #1;
`endif
        @(negedge CLK);
        check(name, Output, exp);
        @(posedge CLK); #1;
    endtask

    initial begin
        RST = 1'b1; WE = 1'b0; Data = '0; Address = '0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        chk_en = 1'b1;

        read_expect("reset_addr0", 6'd0, 8'h00);
        read_expect("reset_addr63", 6'd63, 8'h00);

        do_write(6'd0, 8'hB5);
        read_expect("wr_rd_0", 6'd0, 8'hB5);
        do_write(6'd1, 8'hD4);
        read_expect("wr_rd_1", 6'd1, 8'hD4);
        do_write(6'd2, 8'hA3);
        read_expect("wr_rd_2", 6'd2, 8'hA3);
        read_expect("keep_0", 6'd0, 8'hB5);

        do_write(6'd63, 8'h5A);
        read_expect("no_alias_0", 6'd0, 8'hB5);
        read_expect("top_63", 6'd63, 8'h5A);

        Address = 6'd1; Data = 8'hFF; WE = 1'b0;
        repeat (3) begin @(posedge CLK); #1; end
        read_expect("we0_hold_1", 6'd1, 8'hD4);

        RST = 1'b1; WE = 1'b1; Data = 8'h77; Address = 6'd2;
        @(posedge CLK); #1;
        RST = 1'b0; WE = 1'b0;
        read_expect("rst_clr_0", 6'd0, 8'h00);
        read_expect("rst_clr_1", 6'd1, 8'h00);
        read_expect("rst_drop_wr_2", 6'd2, 8'h00);
        read_expect("rst_clr_63", 6'd63, 8'h00);

        do_write(6'd5, 8'h11);
`ifdef SPRAM_OUT_REG_EN
        Address = 6'd5; WE = 1'b0;
        @(posedge CLK); #1;
        WE = 1'b1; Data = 8'h22;
        @(negedge CLK);
        check("rdw_before_edge", Output, 8'h11);
        @(posedge CLK); #1;
        WE = 1'b0;
        @(negedge CLK);
        check("rdw_read_first", Output, 8'h11);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("rdw_after_edge", Output, 8'h22);
        @(posedge CLK); #1;
`else
        Address = 6'd5; WE = 1'b1; Data = 8'h22;
        @(negedge CLK);
        check("rdw_before_edge", Output, 8'h11);
        @(posedge CLK); #1;
        WE = 1'b0;
        @(negedge CLK);
        check("rdw_after_edge", Output, 8'h22);
        @(posedge CLK); #1;
`endif

        for (int n = 0; n < 400; n++) begin
            RST = ($urandom_range(0, 39) == 0);
            WE = 1'($urandom_range(0, 1));
            Address = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            Data = DW'($urandom);
            @(posedge CLK); #1;
        end
        RST = 1'b0; WE = 1'b0;
        @(negedge CLK);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
